// File: rtl/conv_net_top.sv
// Streaming 3x3 valid-padding convolution: two row delays feed a 3x3 window,
// then a registered multiply stage and a registered adder-tree stage.
module conv_tap (
  input  logic               clk,
  input  logic signed [7:0]  w,
  input  logic [7:0]         pix,
  output logic signed [16:0] prod
);
  always_ff @(posedge clk)
    prod <= w * $signed({1'b0, pix});
endmodule

module conv_net_top #(
  parameter int          IMG_W  = 8,
  parameter int          IMG_H  = 8,
  parameter logic [71:0] KERNEL = 72'h010101010101010101,
  parameter int          ACC_W  = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              d_in,
  input  logic                    conv_start,
  output logic signed [ACC_W-1:0] d_out,
  output logic                    d_out_valid,
  output logic                    frame_done
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [IMG_W-1:0][7:0] lb1, lb2;
  logic [2:0][2:0][7:0]  win;        // win[i][j]: i = window row, j = window col
  logic [2:0] vld_pipe, eof_pipe;
  logic signed [16:0]      prod [9];
  logic signed [ACC_W-1:0] sum;

  // Row delays and window only move on accept; no reset needed because
  // row/col gating keeps stale contents out of any emitted result.
  always_ff @(posedge clk) begin
    if (!rst && conv_start) begin
      lb1 <= {lb1[IMG_W-2:0], d_in};
      lb2 <= {lb2[IMG_W-2:0], lb1[IMG_W-1]};
      for (int i = 0; i < 3; i++) begin
        win[i][0] <= win[i][1];
        win[i][1] <= win[i][2];
      end
      win[0][2] <= lb2[IMG_W-1];
      win[1][2] <= lb1[IMG_W-1];
      win[2][2] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      vld_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      vld_pipe[0] <= conv_start && (row >= ROW_TWO) && (col >= COL_TWO);
      eof_pipe[0] <= conv_start && (row == ROW_LAST) && (col == COL_LAST);
      vld_pipe[2:1] <= vld_pipe[1:0];
      eof_pipe[2:1] <= eof_pipe[1:0];
      if (conv_start) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  for (genvar k = 0; k < 9; k++) begin : g_tap
    conv_tap u_tap (
      .clk  (clk),
      .w    ($signed(KERNEL[8*k +: 8])),
      .pix  (win[k/3][k%3]),
      .prod (prod[k])
    );
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < 9; k++)
      sum = sum + ACC_W'(prod[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
    end else if (vld_pipe[1]) begin
      d_out <= sum;
    end
  end

  assign d_out_valid = vld_pipe[2];
  assign frame_done  = eof_pipe[2];
endmodule

// File: tb/tb_conv_net_top.sv
// Scoreboard bench: three kernels (all-ones, centre 1, centre -128) share one
// stimulus stream; a reference model queues expected results per accept.
module tb_conv_net_top;
  localparam int W = 8, H = 8, AW = 20;
  localparam logic [71:0] K0 = 72'h010101010101010101;
  localparam logic [71:0] K1 = 72'h0000_0000_0100_0000_00;
  localparam logic [71:0] K2 = 72'h0000_0000_8000_0000_00;

  logic clk = 0, rst, conv_start;
  logic [7:0] d_in;
  logic signed [AW-1:0] d0, d1, d2;
  logic v0, v1, v2, f0, f1, f2;

  conv_net_top #(.IMG_W(W), .IMG_H(H), .KERNEL(K0), .ACC_W(AW)) dut0 (
    .clk(clk), .rst(rst), .d_in(d_in), .conv_start(conv_start),
    .d_out(d0), .d_out_valid(v0), .frame_done(f0));
  conv_net_top #(.IMG_W(W), .IMG_H(H), .KERNEL(K1), .ACC_W(AW)) dut1 (
    .clk(clk), .rst(rst), .d_in(d_in), .conv_start(conv_start),
    .d_out(d1), .d_out_valid(v1), .frame_done(f1));
  conv_net_top #(.IMG_W(W), .IMG_H(H), .KERNEL(K2), .ACC_W(AW)) dut2 (
    .clk(clk), .rst(rst), .d_in(d_in), .conv_start(conv_start),
    .d_out(d2), .d_out_valid(v2), .frame_done(f2));

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int e0, e1, e2;
    bit fd;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_cmp = 0, n_bad = 0;
  int n_valid = 0, n_fd = 0;
  int img [H][W];
  int r = 0, c = 0, pn = 0;
  bit in_rst = 0, want_first = 0;
  int first_v0 = 0;
  int last0 = 0, last1 = 0, last2 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int conv(input logic [71:0] k, input int rr, input int cc);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        int wt;
        wt = $signed(k[8*(i*3+j) +: 8]);
        s += wt * img[rr-2+i][cc-2+j];
      end
    return s;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Drive one cycle; when acc=1 the model records the pixel and queues a result.
  task automatic drive(input logic [7:0] p, input bit acc);
    d_in = p;
    conv_start = acc;
    if (acc) begin
      exp_t e;
      img[r][c] = int'(p);
      if (r >= 2 && c >= 2) begin
        e.due = cyc + 3;
        e.e0 = conv(K0, r, c);
        e.e1 = conv(K1, r, c);
        e.e2 = conv(K2, r, c);
        e.fd = (r == H-1 && c == W-1);
        q.push_back(e);
      end
      if (c == W-1) begin
        c = 0;
        r = (r == H-1) ? 0 : r + 1;
      end else c++;
    end
    @(posedge clk); #1;
  endtask

  task automatic drain_and_count(input string name, input int nv, input int nf);
    conv_start = 0;
    repeat (4) @(posedge clk);
    #1;
    check({name, "_results"}, n_valid, nv);
    check({name, "_frame_done"}, n_fd, nf);
    n_valid = 0;
    n_fd = 0;
  endtask

  always @(negedge clk) begin
    if (in_rst) begin
      check("rst_d_out", int'(d0) | int'(d1) | int'(d2), 0);
      check("rst_valid", {29'd0, v0, v1, v2}, 0);
      check("rst_frame_done", {29'd0, f0, f1, f2}, 0);
    end
    if (v1 != v0 || v2 != v0 || f1 != f0 || f2 != f0) begin
      n_cmp++; n_bad++;
      $display("FAIL lane_agree: valid %b%b%b fd %b%b%b at cycle %0d", v0, v1, v2, f0, f1, f2, cyc);
    end
    if (v0) begin
      n_valid++;
      if (f0) n_fd++;
      last0 = d0; last1 = d1; last2 = d2;
      if (want_first) begin first_v0 = d0; want_first = 0; end
      if (q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_valid: got d_out %0d, expected no result at cycle %0d", d0, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (e.due != cyc || int'(d0) != e.e0 || int'(d1) != e.e1 || int'(d2) != e.e2 || f0 != e.fd) begin
          n_bad++;
          $display("FAIL result: got cyc %0d d %0d/%0d/%0d fd %b, expected cyc %0d d %0d/%0d/%0d fd %b",
                   cyc, d0, d1, d2, f0, e.due, e.e0, e.e1, e.e2, e.fd);
        end
      end
    end else begin
      if (f0) begin
        n_cmp++; n_bad++;
        $display("FAIL frame_done_no_valid: got 1, expected 0 at cycle %0d", cyc);
      end
      if (q.size() != 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missing_result: got no valid, expected %0d at cycle %0d", e.e0, e.due);
      end
    end
  end

  initial begin
    rst = 1; conv_start = 1; d_in = 8'd1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      in_rst = 1;
      d_in = 8'((i + 1) % 5 + 1);
    end
    rst = 0; in_rst = 0;

    // Two back-to-back frames of the 1..5 pattern, no idle cycles.
    want_first = 1;
    for (int n = 0; n < 2*W*H; n++) drive(8'(n % 5 + 1), 1);
    drain_and_count("b2b", 72, 2);
    check("first_result", first_v0, 25);

    // Same stream with accept toggling; idle-cycle d_in is garbage.
    for (int n = 0; n < W*H; n++) begin
      drive(8'(n % 5 + 1), 1);
      drive(8'($urandom_range(0, 255)), 0);
    end
    drain_and_count("toggle", 36, 1);

    for (int n = 0; n < W*H; n++) drive(8'($urandom_range(0, 255)), 1);
    drain_and_count("random", 36, 1);

    for (int n = 0; n < W*H; n++) drive(8'd255, 1);
    drain_and_count("sat255", 36, 1);
    check("ones_255", last0, 2295);
    check("centre1_255", last1, 255);
    check("centre_m128_255", last2, -32640);

    // Partial frame into row 4, one-cycle reset, then a full clean frame.
    for (int n = 0; n < 4*W + 3; n++) drive(8'($urandom_range(0, 255)), 1);
    rst = 1; conv_start = 1; d_in = 8'hAA;
    @(posedge clk); #1;
    q.delete();
    r = 0; c = 0;
    rst = 0;
    n_valid = 0; n_fd = 0;
    want_first = 1;
    for (int n = 0; n < W*H; n++) drive(8'(n * 7 + 3), 1);
    drain_and_count("after_rst", 36, 1);
    check("after_rst_first", first_v0,
          3 + 10 + 17 + 59 + 66 + 73 + 115 + 122 + 129);

    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/conv_net_top.md
Name: conv_net_top

Overview:
- Streaming 3x3 2-D convolution engine; top of the convolution datapath.
- Takes one unsigned 8-bit pixel per clock in raster order and buffers the two previous image rows in internal line buffers.
- Emits one signed convolution result per valid ("valid-padding") 3x3 window, with a registered valid strobe and an end-of-frame pulse.

Parameters:
- IMG_W, 8, pixels per row (>=3).
- IMG_H, 8, rows per frame (>=3).
- KERNEL, 72'h010101010101010101, nine signed 8-bit weights; weight k = i*3+j (i = window row 0..2 top-to-bottom, j = window col 0..2 left-to-right) at bits [8k+7:8k].
- ACC_W, 20, output/accumulator width, signed.

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- rst, input, 1, synchronous active-high reset.
- d_in, input, 8, unsigned pixel.
- conv_start, input, 1, pixel-accept enable; d_in is consumed on every edge where conv_start=1 and rst=0.
- d_out, output, ACC_W, signed convolution result.
- d_out_valid, output, 1, d_out holds a new result this cycle.
- frame_done, output, 1, one-cycle pulse coincident with the last result of a frame.

Behaviour:
- Reset (rst=1 at an edge):
  - col, row, pipeline valids and all outputs are cleared to 0.
  - Line-buffer contents need not be cleared.
  - rst dominates conv_start. While rst is held, nothing is accepted and outputs stay 0.
- Accept: conv_start=1 and rst=0 at an edge accepts d_in as pixel (row, col).
  - col increments; at IMG_W-1 it wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1) both wrap to 0; the next accepted pixel starts a new frame.
- Stall: conv_start=0 means no accept; counters, line buffers and the window hold. Results already in the pipeline still emerge on schedule.
- Line buffers: two IMG_W-deep 8-bit row delays.
  - The 3x3 window shift register advances only on accept.
  - The window columns are {row-2, row-1, row} at the current column.
- Window validity: a pixel accepted at row>=2 and col>=2 completes the window covering rows row-2..row and cols col-2..col.
- Result:
  - Computed as the sum over i,j of KERNEL[i*3+j] (signed) times pixel[row-2+i][col-2+j], where pixels are zero-extended to signed 9 bits.
  - Full-precision signed sum in ACC_W bits; no saturation, no ReLU.
  - Defaults cannot overflow: 9*255*128 < 2^19.
- Latency: a window-completing pixel accepted at edge N gives d_out and d_out_valid=1 after edge N+2.
  - Exactly 2 cycles, pipelined as multiply stage then adder-tree stage.
  - Throughput is 1 result per clock.
- d_out_valid is 0 on all other cycles. d_out holds its last value while valid=0 (verification checks it only when valid=1).
- frame_done=1 on the same cycle as the result for pixel (IMG_H-1, IMG_W-1). It is 0 otherwise.
- Outputs per frame: exactly (IMG_W-2)*(IMG_H-2). No result is produced for windows straddling a row wrap (col<2) or a frame wrap (row<2).
- Reset mid-frame:
  - In-flight results are discarded (valids cleared).
  - The next accepted pixel is (0,0).
  - Stale line-buffer data is never used, because row<2 gating applies.
- Back-to-back frames with no idle cycles are supported.

Test Plan:
- rst held at 1 for 100 cycles with conv_start=1 and d_in cycling 1,2,3,4,5 -> d_out=0, d_out_valid=0, frame_done=0 throughout.
- Release rst; conv_start=1; d_in repeats 1,2,3,4,5 (pixel n = (n mod 5)+1); default kernel, IMG_W=IMG_H=8:
  - First result is 25 (1+2+3 + 4+5+1 + 2+3+4), valid 2 cycles after accepting pixel index 18.
  - Exactly 36 valid results per frame.
  - frame_done is high with the 36th result only.
- Same stream with conv_start toggled 1,0,1,0 -> identical result sequence. Each result appears 2 cycles after its completing accept; no valid is produced for non-accept cycles.
- KERNEL with centre weight 1 and all others 0; random pixels -> each result equals pixel[row-1][col-1] zero-extended. Repeat with centre weight -128 and pixels 255 -> result -32640.
- Assert rst for 1 cycle mid-frame (row 4) -> no valid for 2 cycles.
  - Next frame restarts at (0,0).
  - First result appears after accept index 2*IMG_W+2 and is correct.
- Two back-to-back frames, no gaps -> 72 results, frame_done pulses exactly twice, and second-frame values are unaffected by first-frame data.
